psum_mac_ctrl: RTL

//   Multiply-accumulate front end for the PE partial-sum scratchpad (PSpad). Accepts
//   (ifmap, weight, psum index) operands and multiplies them. Performs a read-modify-write
//   of the addressed psum entry through the PSpad port: combinational read, write on the

---
 rtl/psum_mac_ctrl_pkg.sv | 16 +
 rtl/psum_add_sat.sv | 35 +++
 rtl/psum_mac_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/psum_mac_ctrl_pkg.sv
// Shared PE definitions: controller FSM encoding and default datapath geometry,
// also used when sizing the PSpad instance that sits next to the MAC controller.
package psum_mac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } pe_state_t;

    localparam int PE_IN_W = 8;
    localparam int PE_PS_W = 24;
    localparam int PE_ADDR = 5;
    localparam int PE_SIZE = 32;

endpackage

// File: rtl/psum_add_sat.sv
// Partial-sum adder: sign-extends the product, adds it to the base psum in PS_W+1 bits
// and optionally clamps the result to the signed PS_W range. Purely combinational.
module psum_add_sat #(
    parameter int PROD_W = 16,
    parameter int PS_W   = 24,
    parameter int SAT    = 0
) (
    input  logic [PS_W-1:0]   i_base,
    input  logic [PROD_W-1:0] i_prod,
    output logic [PS_W-1:0]   o_sum
);

    localparam logic [PS_W-1:0] MAX_VAL = {1'b0, {(PS_W-1){1'b1}}};
    localparam logic [PS_W-1:0] MIN_VAL = {1'b1, {(PS_W-1){1'b0}}};

    logic [PS_W:0] w_base_ext;
    logic [PS_W:0] w_prod_ext;
    logic [PS_W:0] w_sum;
    logic          w_ovf;

    assign w_base_ext = {i_base[PS_W-1], i_base};
    assign w_prod_ext = {{(PS_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};
    assign w_sum      = w_base_ext + w_prod_ext;

    // The extra top bit disagreeing with the PS_W sign bit means the signed range was left.
    assign w_ovf = w_sum[PS_W] ^ w_sum[PS_W-1];

    always_comb begin
        o_sum = w_sum[PS_W-1:0];
        if ((SAT != 0) && w_ovf) begin
            o_sum = w_sum[PS_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/psum_mac_ctrl.sv
// MAC front end for the PE psum scratchpad: two-stage multiply / read-modify-write,
// followed on request by an in-order drain of all psums over a valid/ready stream.
module psum_mac_ctrl
    import psum_mac_ctrl_pkg::*;
#(
    parameter int IN_W         = PE_IN_W,
    parameter int PS_W         = PE_PS_W,
    parameter int ADDR         = PE_ADDR,
    parameter int SIZE         = PE_SIZE,
    parameter int SAT          = 0,
    parameter int CLR_ON_DRAIN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] ifmap,
    input  logic signed [IN_W-1:0] weight,
    input  logic [ADDR-1:0]        ps_idx,
    input  logic                   first,
    input  logic                   drain_req,
    output logic                   drain_valid,
    input  logic                   drain_ready,
    output logic [PS_W-1:0]        drain_data,
    output logic                   drain_done,
    output logic                   busy,
    output logic                   ps_wen,
    output logic                   ps_ren,
    output logic [ADDR-1:0]        ps_addr,
    output logic [PS_W-1:0]        ps_wrdata,
    input  logic [PS_W-1:0]        ps_rdata
);

    localparam int              PROD_W   = 2 * IN_W;
    localparam logic [ADDR-1:0] LAST_PTR = ADDR'(SIZE - 1);

    pe_state_t                 r_state;
    pe_state_t                 w_next_state;
    logic                      r_s1_valid;
    logic signed [PROD_W-1:0]  r_s1_prod;
    logic [ADDR-1:0]           r_s1_idx;
    logic                      r_s1_first;
    logic [ADDR-1:0]           r_ptr;

    logic                      w_accept;
    logic                      w_beat;
    logic signed [PROD_W-1:0]  w_ifmap_ext;
    logic signed [PROD_W-1:0]  w_weight_ext;
    logic signed [PROD_W-1:0]  w_prod;
    logic [PS_W-1:0]           w_base;
    logic [PS_W-1:0]           w_sum;

    // Held low during reset so no operand is taken while the pipeline is clearing.
    assign in_ready = rst_n && (r_state == ST_IDLE) && !drain_req;
    assign w_accept = in_valid && in_ready;
    assign w_beat   = (r_state == ST_DRAIN) && drain_ready;

    assign w_ifmap_ext  = {{IN_W{ifmap[IN_W-1]}}, ifmap};
    assign w_weight_ext = {{IN_W{weight[IN_W-1]}}, weight};
    assign w_prod       = w_ifmap_ext * w_weight_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_idx   <= '0;
            r_s1_first <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod  <= w_prod;
                r_s1_idx   <= ps_idx;
                r_s1_first <= first;
            end
        end
    end

    // Pointer parks at 0 outside DRAIN so every drain starts from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state != ST_DRAIN) begin
            r_ptr <= '0;
        end else if (drain_ready) begin
            r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + ADDR'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (drain_req && !r_s1_valid)     w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_beat && r_ptr == LAST_PTR)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign w_base = r_s1_first ? '0 : ps_rdata;

    psum_add_sat #(
        .PROD_W (PROD_W),
        .PS_W   (PS_W),
        .SAT    (SAT)
    ) u_add (
        .i_base (w_base),
        .i_prod (r_s1_prod),
        .o_sum  (w_sum)
    );

    // Stage 1 and DRAIN never overlap: DRAIN is entered only with stage 1 empty.
    always_comb begin
        ps_ren    = 1'b0;
        ps_wen    = 1'b0;
        ps_addr   = '0;
        ps_wrdata = '0;
        if (r_s1_valid) begin
            ps_ren    = 1'b1;
            ps_wen    = 1'b1;
            ps_addr   = r_s1_idx;
            ps_wrdata = w_sum;
        end else if (r_state == ST_DRAIN) begin
            ps_ren  = 1'b1;
            ps_addr = r_ptr;
            ps_wen  = (CLR_ON_DRAIN != 0) && drain_ready;
        end
    end

    assign drain_valid = (r_state == ST_DRAIN);
    assign drain_data  = drain_valid ? ps_rdata : '0;
    assign drain_done  = (r_state == ST_DONE);
    assign busy        = r_s1_valid || (r_state != ST_IDLE);

endmodule
